// File: rtl/imem_loader.sv
// Boot loader: length-prefixed big-endian byte stream -> sequential 32-bit instruction-memory writes; holds core in reset until done.
// Latency: im_we pulses the cycle after a word's fourth byte is accepted; cpu_rst drops one cycle after entering DONE.
// Backpressure: never stalls while loading (in_ready=1 in HDR_HI/HDR_LO/DATA); in_ready=0 in DONE/ERR until start re-arms.
module imem_loader #(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_HDR_HI,
        S_HDR_LO,
        S_DATA,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] count;
    logic [15:0] word_idx;
    logic [1:0]  byte_idx;
    logic [23:0] word_buf;
    logic        accept;
    logic [15:0] hdr_count;
    logic        last_byte;

    assign accept    = in_valid && in_ready;
    assign hdr_count = {count[15:8], in_data};
    assign last_byte = (byte_idx == 2'd3) && (word_idx == count - 16'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_HDR_HI;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_HDR_HI: if (accept) state_nxt = S_HDR_LO;
            S_HDR_LO: begin
                if (accept) begin
                    if (hdr_count == 16'd0)               state_nxt = S_DONE;
                    else if ({1'b0, hdr_count} > MAX_W)   state_nxt = S_ERR;
                    else                                  state_nxt = S_DATA;
                end
            end
            S_DATA:   if (accept && last_byte) state_nxt = S_DONE;
            S_DONE,
            S_ERR:    if (start) state_nxt = S_HDR_HI;
            default:  state_nxt = S_HDR_HI;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        unique case (state)
            S_HDR_HI,
            S_HDR_LO,
            S_DATA: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            S_DONE:  done = 1'b1;
            S_ERR:   err  = 1'b1;
            default: busy = 1'b1;
        endcase
    end

    // cpu_rst is registered off the state, so it drops only on the second DONE cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count    <= '0;
            word_idx <= '0;
            byte_idx <= '0;
            word_buf <= '0;
            im_we    <= 1'b0;
            im_addr  <= '0;
            im_wdata <= '0;
            cpu_rst  <= 1'b1;
        end else begin
            im_we   <= 1'b0;
            cpu_rst <= !((state == S_DONE) && !start);
            unique case (state)
                S_HDR_HI: if (accept) count[15:8] <= in_data;
                S_HDR_LO: begin
                    if (accept) begin
                        count[7:0] <= in_data;
                        byte_idx   <= '0;
                        word_idx   <= '0;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        if (byte_idx == 2'd3) begin
                            im_we    <= 1'b1;
                            im_addr  <= word_idx[ADDR_W-1:0];
                            im_wdata <= {word_buf, in_data};
                            word_idx <= word_idx + 16'd1;
                            byte_idx <= '0;
                        end else begin
                            word_buf <= {word_buf[15:0], in_data};
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end
                end
                S_DONE,
                S_ERR: begin
                    if (start) begin
                        byte_idx <= '0;
                        word_idx <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader sitting directly upstream of the single-cycle MIPS core's instruction memory; replaces simulation-only hex-file loading with a byte-stream load path.
- Accepts a length-prefixed byte stream over a valid/ready handshake, packs bytes big-endian into 32-bit words, and writes them sequentially into instruction memory from word 0.
- Holds the core in reset until the load completes, then releases it so the IFU fetches from PC 0.

Parameters:
ADDR_W, 10, instruction-memory word-address width (1024 words)
MAX_WORDS, 2**ADDR_W, largest accepted program length in words

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  single-cycle pulse; re-arms loader from DONE or ERR
in_valid  input  1  byte on in_data is valid
in_data  input  8  stream byte
in_ready  output  1  loader can accept a byte
im_we  output  1  instruction-memory write enable, one-cycle pulse per word
im_addr  output  ADDR_W  word index being written
im_wdata  output  32  word being written
cpu_rst  output  1  active-high reset to mips core (core's reset polarity)
busy  output  1  load in progress (HDR_HI, HDR_LO, DATA)
done  output  1  load finished successfully; level
err  output  1  header length exceeded MAX_WORDS; level

Behaviour:
- Byte accepted only on a rising clk edge with in_valid && in_ready; no other cycle changes state.
- Reset (rst low, async): state HDR_HI, in_ready=1, im_we=0, im_addr=0, im_wdata=0, cpu_rst=1, busy=1, done=0, err=0, word count=0, byte index=0.
- States: HDR_HI, HDR_LO, DATA, DONE, ERR.
- HDR_HI: accepted byte -> count[15:8]; go HDR_LO.
- HDR_LO: accepted byte -> count[7:0]; full 16-bit count evaluated combinationally with this byte:
  - count==0 -> DONE.
  - count>MAX_WORDS -> ERR.
  - otherwise -> DATA; byte index=0, word index=0.
- DATA:
  - in_ready=1 always; no backpressure, because each memory write takes one cycle.
  - Byte index 0..3 fills word bits [31:24], [23:16], [15:8], [7:0] in that order.
  - On acceptance of byte index 3: next cycle im_we=1 for exactly one cycle, im_addr=current word index, im_wdata=assembled word; word index increments; byte index wraps to 0.
  - im_addr/im_wdata hold their last values when im_we=0.
  - When the final word's byte 3 is accepted, state moves to DONE on the same edge that raises im_we.
- DONE: in_ready=0, busy=0, done=1. cpu_rst falls one cycle after the final im_we pulse, i.e. in the second DONE cycle. For count==0, cpu_rst falls on the first DONE edge after HDR_LO.
- ERR: in_ready=0, busy=0, err=1, cpu_rst=1; no memory writes.
- start:
  - In DONE or ERR: go HDR_HI; clear done and err; cpu_rst=1, busy=1; word/byte indices=0.
  - In HDR_HI, HDR_LO or DATA: ignored.
  - Coinciding with an accepted byte: impossible, since in_ready=0 in DONE/ERR.
- Stream bytes arriving in DONE/ERR are not accepted; the source must hold them.
- Reset mid-load: immediate return to reset values; a partial word is discarded, with no write; the next accepted byte is treated as HDR_HI.
- No timeout. A stalled stream leaves the loader in its current state indefinitely, with cpu_rst=1.

Test Plan:
- Reset, then stream 00 02 20 08 00 05 01 09 50 20 with in_valid held high -> im_we pulses: addr 0 data 0x20080005, then addr 1 data 0x01095020. done=1 from the second pulse's cycle; cpu_rst=0 one cycle later. Exactly 2 writes.
- Same stream with in_valid deasserted 1-3 cycles between bytes -> identical writes and data; im_we never asserted during gaps; no duplicate writes.
- Stream 00 00 -> DONE after the second byte; done=1, zero im_we pulses, cpu_rst=0 on the next cycle.
- ADDR_W=10, header 04 01 (1025 words) -> err=1, in_ready=0, cpu_rst=1, no writes. Pulse start -> err=0, busy=1, in_ready=1; stream 00 01 AA BB CC DD -> addr 0 data 0xAABBCCDD.
- After header 00 02 plus data bytes 11 22, pull rst low -> outputs at reset values asynchronously, no write. Release rst, stream 00 01 12 34 56 78 -> single write, addr 0 data 0x12345678.
- Pulse start during DATA -> ignored, load completes normally. Pulse start in DONE and reload 1 word 0xDEADBEEF -> addr 0 overwritten, cpu_rst high throughout the reload and low again after it.
